// File: rtl/fetch_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Control FSM for instruction fetch and PC update in the 8-bit
//                core. It drives the PC controls and the instruction-memory
//                handshake, latches the opcode and operand, resolves jumps,
//                and hands one instruction at a time to the execute stage.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_reset,
    output logic              pc_load,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] pc_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        ir,
    output logic [7:0]        operand,
    output logic              exec_start,
    input  logic              exec_done,
    input  logic              flag_z,
    input  logic              flag_c,
    output logic              halted,
    output logic              fault
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The wait counter only has to reach TIMEOUT-1: the cycle in which it sits
    // at that value without an ack is the TIMEOUT-th wait cycle.
    localparam int                 c_CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit                 c_TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST  = c_CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    localparam logic [3:0] c_ST_PCRST   = 4'd0;
    localparam logic [3:0] c_ST_IDLE    = 4'd1;
    localparam logic [3:0] c_ST_FETCH   = 4'd2;
    localparam logic [3:0] c_ST_DECODE  = 4'd3;
    localparam logic [3:0] c_ST_OPFETCH = 4'd4;
    localparam logic [3:0] c_ST_OPNEXT  = 4'd5;
    localparam logic [3:0] c_ST_EXEC    = 4'd6;   // exec_start cycle
    localparam logic [3:0] c_ST_EXWAIT  = 4'd7;   // waiting for exec_done
    localparam logic [3:0] c_ST_HALT    = 4'd8;
    localparam logic [3:0] c_ST_FAULT   = 4'd9;

    localparam logic [1:0] c_CLS_EXEC = 2'b00;
    localparam logic [1:0] c_CLS_IMM  = 2'b01;
    localparam logic [1:0] c_CLS_JUMP = 2'b10;
    localparam logic [1:0] c_CLS_MISC = 2'b11;
    localparam logic [7:0] c_OP_HLT   = 8'hFF;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [3:0]         r_state;
    logic [3:0]         w_next_state;
    logic               r_started;     // low for the first cycle after reset
    logic [7:0]         r_ir;
    logic [7:0]         r_operand;
    logic [ADDR_W-1:0]  r_pc_target;
    logic [c_CNT_W-1:0] r_wait_cnt;

    logic [1:0]         w_class;
    logic               w_is_halt;
    logic               w_jump_take;
    logic               w_timeout;
    logic               w_in_memwait;
    logic [3:0]         w_boundary;

    assign w_class      = r_ir[7:6];
    assign w_is_halt    = (r_ir == c_OP_HLT);
    assign w_in_memwait = (r_state == c_ST_FETCH) || (r_state == c_ST_OPFETCH);
    assign w_timeout    = c_TIMEOUT_EN && (r_wait_cnt == c_WAIT_LAST);
    assign w_boundary   = run ? c_ST_FETCH : c_ST_IDLE;

    // Jump condition selected by the low opcode bits, using the live flags
    always_comb begin
        w_jump_take = 1'b0;
        case (r_ir[1:0])
            2'b00:   w_jump_take = 1'b1;
            2'b01:   w_jump_take = flag_z;
            2'b10:   w_jump_take = flag_c;
            default: w_jump_take = !flag_z;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // Hold the FSM state; reset aborts whatever is in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_PCRST;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Delay the PC clear by one edge so that every output is 0 while reset is
    // held and pc_reset is a full clock cycle after reset is released
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // Sequence fetch, decode, operand fetch, PC update and execute handoff
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_PCRST: begin
                if (r_started) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_IDLE: begin
                if (run) begin
                    w_next_state = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                // An ack in the final wait cycle takes priority over the timeout
                if (mem_ack) begin
                    w_next_state = c_ST_DECODE;
                end else if (w_timeout) begin
                    w_next_state = c_ST_FAULT;
                end
            end
            c_ST_DECODE: begin
                case (w_class)
                    c_CLS_EXEC: w_next_state = c_ST_EXEC;
                    c_CLS_IMM,
                    c_CLS_JUMP: w_next_state = c_ST_OPFETCH;
                    default:    w_next_state = w_is_halt ? c_ST_HALT : w_boundary;
                endcase
            end
            c_ST_OPFETCH: begin
                if (mem_ack) begin
                    w_next_state = c_ST_OPNEXT;
                end else if (w_timeout) begin
                    w_next_state = c_ST_FAULT;
                end
            end
            c_ST_OPNEXT: begin
                w_next_state = (w_class == c_CLS_IMM) ? c_ST_EXEC : w_boundary;
            end
            c_ST_EXEC: begin
                // exec_done is not looked at in the start cycle itself
                w_next_state = c_ST_EXWAIT;
            end
            c_ST_EXWAIT: begin
                if (exec_done) begin
                    w_next_state = w_boundary;
                end
            end
            c_ST_HALT:  w_next_state = c_ST_HALT;
            c_ST_FAULT: w_next_state = c_ST_FAULT;
            default:    w_next_state = c_ST_PCRST;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    // Decode control outputs from the registered state; the only input term is
    // the jump condition, which picks pc_load versus pc_inc in OPNEXT
    always_comb begin
        pc_reset   = (r_state == c_ST_PCRST) && r_started;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        mem_req    = w_in_memwait;
        exec_start = (r_state == c_ST_EXEC);
        halted     = (r_state == c_ST_HALT);
        fault      = (r_state == c_ST_FAULT);
        if (r_state == c_ST_DECODE) begin
            pc_inc = 1'b1;
        end else if (r_state == c_ST_OPNEXT) begin
            if ((w_class == c_CLS_JUMP) && w_jump_take) begin
                pc_load = 1'b1;
            end else begin
                pc_inc = 1'b1;
            end
        end
    end

    // The address bus is forced to 0 whenever no read is requested, which keeps
    // every output at 0 during reset regardless of the external PC
    assign mem_addr  = mem_req ? pc_value : '0;
    assign pc_target = r_pc_target;
    assign ir        = r_ir;
    assign operand   = r_operand;

    // ------------------------------------------------------------------------
    // Datapath latches
    // ------------------------------------------------------------------------
    // Capture opcode in FETCH and operand/jump target in OPFETCH on mem_ack
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ir        <= 8'h00;
            r_operand   <= 8'h00;
            r_pc_target <= '0;
        end else begin
            if ((r_state == c_ST_FETCH) && mem_ack) begin
                r_ir <= mem_rdata;
            end
            if ((r_state == c_ST_OPFETCH) && mem_ack) begin
                r_operand   <= mem_rdata;
                r_pc_target <= ADDR_W'(mem_rdata);
            end
        end
    end

    // Count unacknowledged request cycles; any other cycle clears the count,
    // so it always starts from 0 on entry to FETCH or OPFETCH
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_in_memwait && !mem_ack) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

endmodule
`default_nettype wire
